// File: rtl/dstack_engine.sv
// dstack_engine: register-file data stack with push, pop-one, pop-two and
// partial rotate. The top three cells come straight from flops and there
// is one combinational read port. Overflow, underflow and range errors are
// recorded in sticky fault flags.
// Every non-halted cycle writes next_top into cell 0, so the caller re-supplies
// the current top whenever it wants the top preserved.
module dstack_engine #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  rotate,
  input  logic [4:0]            rotate_addr,
  input  logic                  clear_faults,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [5:0]            count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  range_err
);

  localparam logic [1:0] MV_HOLD = 2'b00;
  localparam logic [1:0] MV_PUSH = 2'b01;
  localparam logic [1:0] MV_POP1 = 2'b10;
  localparam logic [1:0] MV_POP2 = 2'b11;

  // Depth in the same 7-bit width used for count and address arithmetic.
  localparam logic [6:0] DEPTH7 = 7'(DEPTH);
  localparam logic [5:0] DEPTH6 = 6'(DEPTH);

  logic [WORD_WIDTH-1:0] r_cell [DEPTH];
  logic [5:0]            r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_range_err;

  // Cells padded with two zero cells beyond the bottom, so pops can read
  // i+1 / i+2 without going past the end of the array.
  logic [WORD_WIDTH-1:0] w_ext [DEPTH+2];
  logic [WORD_WIDTH-1:0] w_cell_nxt [DEPTH];
  logic [5:0]            w_count_nxt;
  logic [6:0]            w_addr7;
  logic                  w_rot_shift;
  logic [6:0]            w_cnt7;
  logic [6:0]            w_cnt_inc;
  logic [6:0]            w_cnt_dec1;
  logic [6:0]            w_cnt_dec2;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic                  w_rng_evt;

  // Zero-padded view of the cell array used by the pop paths.
  always_comb begin
    for (int i = 0; i < DEPTH + 2; i++) begin
      w_ext[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_ext[i] = r_cell[i];
    end
  end

  // Next value of every cell, chosen by the movement code and the rotate request.
  always_comb begin
    w_addr7     = {2'b00, rotate_addr};
    // A rotate shifts only for 0 < N < DEPTH. N == 0 behaves as a hold.
    w_rot_shift = (movement == MV_HOLD) && rotate &&
                  (rotate_addr != 5'd0) && (w_addr7 < DEPTH7);
    for (int i = 0; i < DEPTH; i++) begin
      w_cell_nxt[i] = r_cell[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      case (movement)
        MV_PUSH: w_cell_nxt[i] = r_cell[i-1];
        MV_POP1: w_cell_nxt[i] = w_ext[i+1];
        MV_POP2: w_cell_nxt[i] = w_ext[i+2];
        default: begin
          // Rotate: cells 1..N take the cell above them. Cells below N keep their value.
          if (w_rot_shift && (7'(i) <= w_addr7)) begin
            w_cell_nxt[i] = r_cell[i-1];
          end
        end
      endcase
    end
    w_cell_nxt[0] = next_top;
  end

  // Count update in 7 bits with saturation to 0..DEPTH, plus fault events.
  always_comb begin
    w_cnt7      = {1'b0, r_count};
    w_cnt_inc   = w_cnt7 + 7'd1;
    w_cnt_dec1  = w_cnt7 - 7'd1;
    w_cnt_dec2  = w_cnt7 - 7'd2;
    w_count_nxt = r_count;
    w_ovf_evt   = 1'b0;
    w_udf_evt   = 1'b0;
    w_rng_evt   = 1'b0;
    case (movement)
      MV_PUSH: begin
        if (w_cnt_inc > DEPTH7) begin
          w_count_nxt = DEPTH6;
          w_ovf_evt   = 1'b1;
        end else begin
          w_count_nxt = w_cnt_inc[5:0];
        end
      end
      MV_POP1: begin
        // Bit 6 set means the subtraction went below zero.
        if (w_cnt_dec1[6]) begin
          w_count_nxt = 6'd0;
          w_udf_evt   = 1'b1;
        end else begin
          w_count_nxt = w_cnt_dec1[5:0];
        end
      end
      MV_POP2: begin
        if (w_cnt_dec2[6]) begin
          w_count_nxt = 6'd0;
          w_udf_evt   = 1'b1;
        end else begin
          w_count_nxt = w_cnt_dec2[5:0];
        end
      end
      default: begin
        w_rng_evt = rotate && (w_addr7 >= DEPTH7);
      end
    endcase
  end

  // State registers. Halt freezes everything, including the fault clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cell[i] <= '0;
      end
      r_count     <= 6'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_range_err <= 1'b0;
    end else if (!halt) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cell[i] <= w_cell_nxt[i];
      end
      r_count     <= w_count_nxt;
      // A fault in the same cycle as clear_faults wins, so the flag reads 1.
      r_overflow  <= (r_overflow  & ~clear_faults) | w_ovf_evt;
      r_underflow <= (r_underflow & ~clear_faults) | w_udf_evt;
      r_range_err <= (r_range_err & ~clear_faults) | w_rng_evt;
    end
  end

  // Combinational read port. An index outside the stack reads as zero.
  always_comb begin
    rotate_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rotate_addr == 5'(i)) begin
        rotate_value = r_cell[i];
      end
    end
  end

  assign top       = r_cell[0];
  assign second    = r_cell[1];
  assign third     = r_cell[2];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_dstack_engine.sv
// Bench for dstack_engine. The main instance uses the default 32-deep stack
// and is checked against a reference model. A 4-deep instance is used for
// the overflow and out-of-range rotate scenarios.
module tb_dstack_engine;

  localparam int W  = 32;
  localparam int EW = 4 * W + 9;
  localparam int DW = 3 * W + 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, halt, rotate, clear_faults;
  logic [1:0]    movement;
  logic [W-1:0]  next_top;
  logic [4:0]    rotate_addr;
  logic [W-1:0]  top, second, third, rotate_value;
  logic [5:0]    count;
  logic          overflow, underflow, range_err;

  logic          d4_rst_n, d4_halt, d4_rotate, d4_clear_faults;
  logic [1:0]    d4_movement;
  logic [W-1:0]  d4_next_top;
  logic [4:0]    d4_rotate_addr;
  logic [W-1:0]  d4_top, d4_second, d4_third, d4_rotate_value;
  logic [5:0]    d4_count;
  logic          d4_overflow, d4_underflow, d4_range_err;

  dstack_engine #(.WORD_WIDTH(W), .DEPTH(32)) u_dut (
    .clk(clk), .reset_n(rst_n), .halt(halt), .movement(movement),
    .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
    .clear_faults(clear_faults), .top(top), .second(second), .third(third),
    .rotate_value(rotate_value), .count(count), .overflow(overflow),
    .underflow(underflow), .range_err(range_err)
  );

  dstack_engine #(.WORD_WIDTH(W), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(d4_rst_n), .halt(d4_halt), .movement(d4_movement),
    .next_top(d4_next_top), .rotate(d4_rotate), .rotate_addr(d4_rotate_addr),
    .clear_faults(d4_clear_faults), .top(d4_top), .second(d4_second),
    .third(d4_third), .rotate_value(d4_rotate_value), .count(d4_count),
    .overflow(d4_overflow), .underflow(d4_underflow), .range_err(d4_range_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] d4_q[$];

  // Reference model of the 32-deep instance.
  logic [W-1:0] m_cell [32];
  int           m_count;
  logic         m_ovf, m_udf, m_rng;

  function automatic logic [EW-1:0] obs_main();
    return {top, second, third, rotate_value, count, overflow, underflow, range_err};
  endfunction

  function automatic logic [DW-1:0] obs_d4();
    return {d4_top, d4_second, d4_third, d4_count, d4_overflow, d4_underflow, d4_range_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cell[i] = '0;
    m_count = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rng = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle on the main instance, predict its result, and queue the prediction.
  task automatic apply(input logic [1:0] mv, input logic rot, input logic [4:0] addr,
                       input logic [W-1:0] nt, input logic clr, input logic hlt);
    logic [W-1:0] old [32];
    int   k;
    logic ovf_e, udf_e, rng_e;
    halt = hlt; movement = mv; rotate = rot; rotate_addr = addr;
    next_top = nt; clear_faults = clr;
    if (!hlt) begin
      old = m_cell;
      ovf_e = 1'b0; udf_e = 1'b0; rng_e = 1'b0;
      case (mv)
        2'b01: begin
          for (int i = 1; i < 32; i++) m_cell[i] = old[i-1];
          if (m_count == 32) ovf_e = 1'b1;
          else m_count++;
        end
        2'b10, 2'b11: begin
          k = (mv == 2'b10) ? 1 : 2;
          for (int i = 1; i < 32; i++) m_cell[i] = (i + k < 32) ? old[i+k] : '0;
          if (m_count < k) begin
            m_count = 0;
            udf_e = 1'b1;
          end else begin
            m_count -= k;
          end
        end
        default: begin
          if (rot) for (int i = 1; i <= int'(addr); i++) m_cell[i] = old[i-1];
        end
      endcase
      m_cell[0] = nt;
      if (clr) begin
        m_ovf = 1'b0; m_udf = 1'b0; m_rng = 1'b0;
      end
      m_ovf = m_ovf | ovf_e;
      m_udf = m_udf | udf_e;
      m_rng = m_rng | rng_e;
    end
    exp_q.push_back({m_cell[0], m_cell[1], m_cell[2], m_cell[addr],
                     6'(m_count), m_ovf, m_udf, m_rng});
    @(posedge clk); #1;
  endtask

  task automatic d4_apply(input logic [1:0] mv, input logic rot, input logic [4:0] addr,
                          input logic [W-1:0] nt, input logic clr, input logic [DW-1:0] exp);
    d4_halt = 1'b0; d4_movement = mv; d4_rotate = rot; d4_rotate_addr = addr;
    d4_next_top = nt; d4_clear_faults = clr;
    d4_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic reset_main();
    halt = 1'b1;
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic reset_d4();
    d4_halt = 1'b1;
    d4_rst_n = 1'b0;
    #2;
    d4_q.delete();
    @(negedge clk);
    d4_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; d4_rst_n = 1'b0;
    halt = 1'b1; movement = 2'b00; rotate = 1'b0; rotate_addr = 5'd0;
    next_top = '0; clear_faults = 1'b0;
    d4_halt = 1'b1; d4_movement = 2'b00; d4_rotate = 1'b0; d4_rotate_addr = 5'd0;
    d4_next_top = '0; d4_clear_faults = 1'b0;
    #2;
    checks++;
    if (obs_main() !== '0) begin
      errors++;
      $display("FAIL reset_main: got %h expected 0", obs_main());
    end
    checks++;
    if (obs_d4() !== '0) begin
      errors++;
      $display("FAIL reset_d4: got %h expected 0", obs_d4());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; d4_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    logic [W-1:0] vals [3];
    logic [EW-1:0] exp;
    vals = '{32'h11, 32'h22, 32'h33};
    reset_main();
    for (int i = 0; i < 3; i++) begin
      apply(2'b01, 1'b0, 5'd0, vals[i], 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_main() !== exp) begin
        errors++;
        $display("FAIL push_%0d: got %h expected %h", i, obs_main(), exp);
      end
    end
    checks++;
    if ({top, second, third, count} !== {32'h33, 32'h22, 32'h11, 6'd3}) begin
      errors++;
      $display("FAIL push3_state: got %h %h %h cnt=%0d expected 33 22 11 cnt=3",
               top, second, third, count);
    end
    apply(2'b11, 1'b0, 5'd0, 32'h11, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_main() !== exp) begin
      errors++;
      $display("FAIL pop_two: got %h expected %h", obs_main(), exp);
    end
    checks++;
    if ({top, second, count, overflow, underflow, range_err} !==
        {32'h11, 32'h0, 6'd1, 3'b000}) begin
      errors++;
      $display("FAIL pop_two_state: got %h %h cnt=%0d flags=%b%b%b expected 11 0 cnt=1 flags=000",
               top, second, count, overflow, underflow, range_err);
    end
  endtask

  task automatic test_rotate();
    logic [EW-1:0] exp;
    reset_main();
    for (int i = 0; i < 5; i++) begin
      apply(2'b01, 1'b0, 5'd3, 32'hA0 + W'(i), 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_main() !== exp) begin
        errors++;
        $display("FAIL rot_push_%0d: got %h expected %h", i, obs_main(), exp);
      end
    end
    checks++;
    if (rotate_value !== 32'hA1) begin
      errors++;
      $display("FAIL rot_read: got %h expected a1", rotate_value);
    end
    apply(2'b00, 1'b1, 5'd3, 32'hA1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_main() !== exp) begin
      errors++;
      $display("FAIL rotate_n3: got %h expected %h", obs_main(), exp);
    end
    checks++;
    if ({top, second, third, rotate_value, count} !==
        {32'hA1, 32'hA4, 32'hA3, 32'hA2, 6'd5}) begin
      errors++;
      $display("FAIL rotate_state: got %h %h %h c3=%h cnt=%0d expected a1 a4 a3 a2 cnt=5",
               top, second, third, rotate_value, count);
    end
    rotate = 1'b0;
    rotate_addr = 5'd4;
    #1;
    checks++;
    if (rotate_value !== 32'hA0) begin
      errors++;
      $display("FAIL rotate_cell4: got %h expected a0", rotate_value);
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] exp;
    logic [1:0]    mv;
    int            r;
    reset_main();
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      mv = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
      apply(mv, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      exp = exp_q.pop_front();
      checks++;
      if (obs_main() !== exp) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", n, obs_main(), exp);
      end
    end
  endtask

  task automatic test_halt_reset();
    logic [EW-1:0] exp;
    apply(2'b01, 1'b0, 5'd1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (obs_main() !== exp) begin
      errors++;
      $display("FAIL halt_freeze: got %h expected %h", obs_main(), exp);
    end
    // Reset asserted between clock edges must clear the outputs before the next edge.
    movement = 2'b01; halt = 1'b0; rotate_addr = 5'd0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_main() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", obs_main());
    end
    model_reset();
    movement = 2'b00; next_top = '0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b01, 1'b0, 5'd0, 32'h77, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_main() !== exp) begin
      errors++;
      $display("FAIL post_reset_push: got %h expected %h", obs_main(), exp);
    end
  endtask

  task automatic test_depth4();
    logic [DW-1:0] exp;
    logic [1:0]    mv_t  [14];
    logic          rot_t [14];
    logic [4:0]    adr_t [14];
    logic [W-1:0]  nt_t  [14];
    logic          clr_t [14];
    logic [DW-1:0] exp_t [14];
    // Overflow sequence, then underflow and out-of-range rotate after a reset.
    mv_t  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
              2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    rot_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    adr_t = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3,
              5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd8, 5'd8};
    nt_t  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd6,
              32'h7, 32'h7, 32'h21, 32'h22, 32'h55, 32'h55, 32'h66};
    clr_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t = '{{32'd1, 32'd0, 32'd0, 6'd1, 3'b000},
              {32'd2, 32'd1, 32'd0, 6'd2, 3'b000},
              {32'd3, 32'd2, 32'd1, 6'd3, 3'b000},
              {32'd4, 32'd3, 32'd2, 6'd4, 3'b000},
              {32'd5, 32'd4, 32'd3, 6'd4, 3'b100},
              {32'd6, 32'd5, 32'd4, 6'd4, 3'b100},
              {32'd6, 32'd5, 32'd4, 6'd4, 3'b000},
              {32'h7, 32'h0, 32'h0, 6'd1, 3'b000},
              {32'h7, 32'h0, 32'h0, 6'd0, 3'b010},
              {32'h21, 32'h7, 32'h0, 6'd1, 3'b010},
              {32'h22, 32'h21, 32'h7, 6'd2, 3'b010},
              {32'h55, 32'h21, 32'h7, 6'd2, 3'b011},
              {32'h55, 32'h21, 32'h7, 6'd2, 3'b001},
              {32'h66, 32'h55, 32'h21, 6'd3, 3'b000}};
    reset_d4();
    for (int i = 0; i < 14; i++) begin
      if (i == 7) reset_d4();
      d4_apply(mv_t[i], rot_t[i], adr_t[i], nt_t[i], clr_t[i], exp_t[i]);
      exp = d4_q.pop_front();
      checks++;
      if (obs_d4() !== exp) begin
        errors++;
        $display("FAIL d4_step_%0d: got %h expected %h", i, obs_d4(), exp);
      end
      if (i == 4) begin
        checks++;
        if (d4_rotate_value !== 32'd2) begin
          errors++;
          $display("FAIL d4_bottom_cell: got %h expected 2", d4_rotate_value);
        end
      end
      if (i == 11) begin
        checks++;
        if (d4_rotate_value !== 32'd0) begin
          errors++;
          $display("FAIL d4_read_out_of_range: got %h expected 0", d4_rotate_value);
        end
      end
    end
    d4_halt = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_push_pop();
    test_rotate();
    test_random();
    test_halt_reset();
    halt = 1'b1;
    test_depth4();
    if (exp_q.size() != 0 || d4_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d and %0d entries left, expected 0",
               exp_q.size(), d4_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
